// File: rtl/reg_scoreboard_if.sv
// Decode-side bundle between ID issue control, writeback/kill retirement and the fence sequencer.
interface reg_scoreboard_if #(
  parameter int IDX_W = 5
);
  logic             issue_valid;
  logic [IDX_W-1:0] issue_ra1;
  logic             issue_use1;
  logic [IDX_W-1:0] issue_ra2;
  logic             issue_use2;
  logic             issue_wen;
  logic [IDX_W-1:0] issue_dst;
  logic             mem_wait;
  logic             issue_ready;
  logic             wb_valid;
  logic [IDX_W-1:0] wb_dst;
  logic             kill_valid;
  logic [IDX_W-1:0] kill_dst;
  logic             fence_req;
  logic             fence_done;
  logic             busy;
  logic             sb_err;

  modport master (
    output issue_valid, issue_ra1, issue_use1, issue_ra2, issue_use2,
           issue_wen, issue_dst, mem_wait, wb_valid, wb_dst,
           kill_valid, kill_dst, fence_req,
    input  issue_ready, fence_done, busy, sb_err
  );

  modport slave (
    input  issue_valid, issue_ra1, issue_use1, issue_ra2, issue_use2,
           issue_wen, issue_dst, mem_wait, wb_valid, wb_dst,
           kill_valid, kill_dst, fence_req,
    output issue_ready, fence_done, busy, sb_err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters gating ID->EX issue, plus a drain-before-issue fence FSM.
// issue_ready is combinational on registered counts; fence_done is >= 2 cycles after fence_req.
module reg_scoreboard #(
  parameter int NREG  = 32,
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  reg_scoreboard_if.slave sb
);
  localparam int IDX_W = $clog2(NREG);
  localparam int SUM_W = CNT_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_e;

  state_e                     state_q, state_d;
  logic [NREG-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                       err_q, err_d;
  logic                       hazard, fire, busy, fence_done;
  logic                       inc, dec_wb, dec_kill;
  logic [SUM_W-1:0]           sum;

  always_comb begin
    hazard = (sb.issue_use1 && (sb.issue_ra1 != '0) && (cnt_q[sb.issue_ra1] != '0))
          || (sb.issue_use2 && (sb.issue_ra2 != '0) && (cnt_q[sb.issue_ra2] != '0))
          || (sb.issue_wen  && (sb.issue_dst != '0) && (cnt_q[sb.issue_dst] == CNT_MAX));
    fire   = sb.issue_valid && !hazard && !sb.mem_wait && (state_q == S_RUN);
    busy   = |cnt_q;
  end

  // All three sources fold into one signed delta so same-cycle issue+retire nets out.
  always_comb begin
    cnt_d    = cnt_q;
    err_d    = err_q;
    inc      = 1'b0;
    dec_wb   = 1'b0;
    dec_kill = 1'b0;
    sum      = '0;
    cnt_d[0] = '0;
    for (int r = 1; r < NREG; r++) begin
      inc      = fire && sb.issue_wen && (sb.issue_dst == IDX_W'(r));
      dec_wb   = sb.wb_valid && (sb.wb_dst == IDX_W'(r));
      dec_kill = sb.kill_valid && (sb.kill_dst == IDX_W'(r));
      sum      = SUM_W'(cnt_q[r]) + SUM_W'(inc) - SUM_W'(dec_wb) - SUM_W'(dec_kill);
      if (sum[SUM_W-1]) begin
        cnt_d[r] = '0;
        err_d    = 1'b1;
      end else if (sum > SUM_W'(CNT_MAX)) begin
        cnt_d[r] = CNT_MAX;
        err_d    = 1'b1;
      end else begin
        cnt_d[r] = sum[CNT_W-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    fence_done = 1'b0;
    case (state_q)
      S_RUN:   if (sb.fence_req) state_d = S_DRAIN;
      S_DRAIN: if (!busy) state_d = S_DONE;
      S_DONE: begin
        fence_done = 1'b1;
        state_d    = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign sb.issue_ready = fire;
  assign sb.fence_done  = fence_done;
  assign sb.busy        = busy;
  assign sb.sb_err      = err_q;
endmodule
